// File: rtl/sync_ctrl_pkg.sv
// Shared types, error bit positions and bus helpers for the barrier sync controller.
package sync_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_RELEASE = 2'd2
    } sync_state_e;

    // Bit positions inside the sticky error vector.
    localparam int ERR_MISMATCH  = 0;
    localparam int ERR_NONMEMBER = 1;
    localparam int ERR_TIMEOUT   = 2;
    localparam int ERR_OVERRUN   = 3;
    localparam int ERR_COUNT     = 4;

    // Upper bounds for the id-extraction helper: up to 32 cores with ids up to 16 bits.
    localparam int SB_MAX_ID_W = 16;
    localparam int SB_BUS_MAX  = 512;

    // Return core 'core' id field of width 'id_w' from the packed request bus.
    function automatic logic [SB_MAX_ID_W-1:0] sb_core_id(
        input logic [SB_BUS_MAX-1:0] bus,
        input int                    id_w,
        input int                    core
    );
        logic [SB_BUS_MAX-1:0] shifted_s;
        logic [SB_BUS_MAX-1:0] field_mask_s;
        shifted_s    = bus >> (id_w * core);
        field_mask_s = (SB_BUS_MAX'(1) << id_w) - SB_BUS_MAX'(1);
        return SB_MAX_ID_W'(shifted_s & field_mask_s);
    endfunction

endpackage

// File: rtl/sync_mask_table.sv
// Host-written barrier membership table: one N_CORES-bit mask per barrier id.
module sync_mask_table #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [N_CORES-1:0] wr_mask,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [N_CORES-1:0] rd_mask
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [N_CORES-1:0] mem_r [DEPTH];

    // Table storage: cleared on reset, one entry written per strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_mask;
        end
    end

    assign rd_mask = mem_r[rd_addr];

endmodule

// File: rtl/sync_barrier_ctrl.sv
// Barrier responder: collects per-core arrivals for one barrier id and
// releases all participating cores with a single-cycle ready pulse.
module sync_barrier_ctrl
    import sync_ctrl_pkg::*;
#(
    parameter int N_CORES            = 4,
    parameter int SYNC_BARRIER_WIDTH = 8,
    parameter int TIMEOUT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES     = 1000
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [N_CORES-1:0]                    sync_enable,
    input  logic [N_CORES*SYNC_BARRIER_WIDTH-1:0] sync_barrier,
    output logic [N_CORES-1:0]                    sync_ready,
    input  logic                                  cfg_write_enable,
    input  logic [SYNC_BARRIER_WIDTH-1:0]         cfg_write_addr,
    input  logic [N_CORES-1:0]                    cfg_write_mask,
    input  logic                                  err_clear,
    output logic                                  busy,
    output logic [SYNC_BARRIER_WIDTH-1:0]         active_barrier,
    output logic                                  err_mismatch,
    output logic                                  err_nonmember,
    output logic                                  err_timeout,
    output logic                                  err_overrun
);

    localparam int W = SYNC_BARRIER_WIDTH;
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    sync_state_e               state_r, state_n;
    logic [N_CORES-1:0]        arrived_r, arrived_n;
    logic [N_CORES-1:0]        active_mask_r, active_mask_n;
    logic [W-1:0]              active_id_r, active_id_n;
    logic [TIMEOUT_WIDTH-1:0]  cnt_r, cnt_n;
    logic [N_CORES-1:0]        ready_r, ready_n;
    logic                      busy_r;
    logic [ERR_COUNT-1:0]      err_r, err_set_s;

    logic [W-1:0]              core_id_s [N_CORES];
    logic                      lead_found_s;
    logic [W-1:0]              lead_id_s;
    logic [N_CORES-1:0]        table_mask_s;
    logic [W-1:0]              ref_id_s;
    logic [N_CORES-1:0]        ref_mask_s;
    logic [N_CORES-1:0]        match_s;
    logic                      mism_any_s;
    logic                      nonmem_any_s;
    logic                      timeout_hit_s;

    sync_mask_table #(
        .N_CORES (N_CORES),
        .ADDR_W  (W)
    ) u_mask_table (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (cfg_write_enable),
        .wr_addr (cfg_write_addr),
        .wr_mask (cfg_write_mask),
        .rd_addr (lead_id_s),
        .rd_mask (table_mask_s)
    );

    // Unpack ids and pick the lowest-index requester as the lead core.
    always_comb begin
        lead_found_s = 1'b0;
        lead_id_s    = '0;
        for (int i = 0; i < N_CORES; i++) begin
            core_id_s[i] = W'(sb_core_id(SB_BUS_MAX'(sync_barrier), W, i));
            if (sync_enable[i] && !lead_found_s) begin
                lead_found_s = 1'b1;
                lead_id_s    = core_id_s[i];
            end else begin
                lead_found_s = lead_found_s;
            end
        end
    end

    // Classify each request against the barrier being formed or collected.
    always_comb begin
        if (state_r == ST_IDLE) begin
            ref_id_s   = lead_id_s;
            ref_mask_s = table_mask_s;
        end else begin
            ref_id_s   = active_id_r;
            ref_mask_s = active_mask_r;
        end
        match_s      = '0;
        mism_any_s   = 1'b0;
        nonmem_any_s = 1'b0;
        for (int i = 0; i < N_CORES; i++) begin
            if (!sync_enable[i]) begin
                match_s[i] = 1'b0;
            end else if (core_id_s[i] != ref_id_s) begin
                mism_any_s = 1'b1;
            end else if (!ref_mask_s[i]) begin
                nonmem_any_s = 1'b1;
            end else begin
                match_s[i] = 1'b1;
            end
        end
        timeout_hit_s = (TIMEOUT_CYCLES != 0) && (cnt_r == TIMEOUT_LAST);
    end

    // Next-state logic for the IDLE -> COLLECT -> RELEASE sequence.
    always_comb begin
        state_n       = state_r;
        arrived_n     = arrived_r;
        active_mask_n = active_mask_r;
        active_id_n   = active_id_r;
        cnt_n         = cnt_r;
        ready_n       = '0;
        err_set_s     = '0;
        case (state_r)
            ST_IDLE: begin
                if (|sync_enable) begin
                    err_set_s[ERR_MISMATCH]  = mism_any_s;
                    err_set_s[ERR_NONMEMBER] = nonmem_any_s || (table_mask_s == '0);
                    if (table_mask_s != '0) begin
                        state_n       = ST_COLLECT;
                        active_id_n   = lead_id_s;
                        active_mask_n = table_mask_s;
                        arrived_n     = match_s;
                        cnt_n         = '0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                err_set_s[ERR_MISMATCH]  = mism_any_s;
                err_set_s[ERR_NONMEMBER] = nonmem_any_s;
                if (timeout_hit_s) begin
                    err_set_s[ERR_TIMEOUT] = 1'b1;
                    arrived_n = '0;
                    cnt_n     = '0;
                    state_n   = ST_IDLE;
                end else if (arrived_r == active_mask_r) begin
                    ready_n = active_mask_r;
                    state_n = ST_RELEASE;
                end else begin
                    arrived_n = arrived_r | match_s;
                    cnt_n     = cnt_r + TIMEOUT_WIDTH'(1);
                end
            end
            ST_RELEASE: begin
                err_set_s[ERR_OVERRUN] = |sync_enable;
                arrived_n = '0;
                cnt_n     = '0;
                state_n   = ST_IDLE;
            end
            default: begin
                arrived_n = '0;
                cnt_n     = '0;
                state_n   = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; sticky errors give set priority over clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            arrived_r     <= '0;
            active_mask_r <= '0;
            active_id_r   <= '0;
            cnt_r         <= '0;
            ready_r       <= '0;
            busy_r        <= 1'b0;
            err_r         <= '0;
        end else begin
            state_r       <= state_n;
            arrived_r     <= arrived_n;
            active_mask_r <= active_mask_n;
            active_id_r   <= active_id_n;
            cnt_r         <= cnt_n;
            ready_r       <= ready_n & active_mask_r;
            busy_r        <= (state_n != ST_IDLE);
            err_r         <= (err_r & ~{ERR_COUNT{err_clear}}) | err_set_s;
        end
    end

    assign sync_ready     = ready_r;
    assign busy           = busy_r;
    assign active_barrier = active_id_r;
    assign err_mismatch   = err_r[ERR_MISMATCH];
    assign err_nonmember  = err_r[ERR_NONMEMBER];
    assign err_timeout    = err_r[ERR_TIMEOUT];
    assign err_overrun    = err_r[ERR_OVERRUN];

endmodule

// File: tb/tb_sync_barrier_ctrl.sv
// Directed testbench for sync_barrier_ctrl with hand-computed expectations.
module tb_sync_barrier_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  sync_enable;
    logic [31:0] sync_barrier;
    logic [3:0]  sync_ready;
    logic        cfg_write_enable;
    logic [7:0]  cfg_write_addr;
    logic [3:0]  cfg_write_mask;
    logic        err_clear;
    logic        busy;
    logic [7:0]  active_barrier;
    logic        err_mismatch;
    logic        err_nonmember;
    logic        err_timeout;
    logic        err_overrun;

    int errors = 0;
    int checks = 0;

    sync_barrier_ctrl #(
        .N_CORES            (4),
        .SYNC_BARRIER_WIDTH (8),
        .TIMEOUT_WIDTH      (16),
        .TIMEOUT_CYCLES     (100)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .sync_enable      (sync_enable),
        .sync_barrier     (sync_barrier),
        .sync_ready       (sync_ready),
        .cfg_write_enable (cfg_write_enable),
        .cfg_write_addr   (cfg_write_addr),
        .cfg_write_mask   (cfg_write_mask),
        .err_clear        (err_clear),
        .busy             (busy),
        .active_barrier   (active_barrier),
        .err_mismatch     (err_mismatch),
        .err_nonmember    (err_nonmember),
        .err_timeout      (err_timeout),
        .err_overrun      (err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [7:0] id, input logic [3:0] m);
        cfg_write_enable = 1'b1;
        cfg_write_addr   = id;
        cfg_write_mask   = m;
        tick();
        cfg_write_enable = 1'b0;
    endtask

    task automatic set_id(input int core, input logic [7:0] id);
        sync_barrier[core*8 +: 8] = id;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (sync_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected %b", sync_ready, 4'b0000); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected %b", busy, 1'b0); end
        checks++; if (active_barrier !== 8'd0) begin errors++; $display("FAIL reset_active: got %0d expected %0d", active_barrier, 8'd0); end
        checks++; if ({err_mismatch, err_nonmember, err_timeout, err_overrun} !== 4'b0000) begin errors++; $display("FAIL reset_errs: got %b expected %b", {err_mismatch, err_nonmember, err_timeout, err_overrun}, 4'b0000); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_two_core();
        cfg_write(8'd5, 4'b0011);
        set_id(0, 8'd5);
        sync_enable = 4'b0001;
        tick();
        sync_enable = 4'b0000;
        checks++; if (active_barrier !== 8'd5) begin errors++; $display("FAIL two_active: got %0d expected %0d", active_barrier, 8'd5); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (busy !== 1'b1 || sync_ready !== 4'b0000) begin errors++; $display("FAIL two_wait: got busy=%b ready=%b expected busy=1 ready=0000", busy, sync_ready); end
            tick();
        end
        set_id(1, 8'd5);
        sync_enable = 4'b0010;
        tick();
        sync_enable = 4'b0000;
        checks++; if (sync_ready !== 4'b0000) begin errors++; $display("FAIL two_early: got %b expected %b", sync_ready, 4'b0000); end
        tick();
        checks++; if (sync_ready !== 4'b0011 || busy !== 1'b1) begin errors++; $display("FAIL two_release: got ready=%b busy=%b expected ready=0011 busy=1", sync_ready, busy); end
        tick();
        checks++; if (sync_ready !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL two_after: got ready=%b busy=%b expected ready=0000 busy=0", sync_ready, busy); end
        checks++; if ({err_mismatch, err_nonmember, err_timeout, err_overrun} !== 4'b0000) begin errors++; $display("FAIL two_errs: got %b expected %b", {err_mismatch, err_nonmember, err_timeout, err_overrun}, 4'b0000); end
    endtask

    task automatic test_single_core();
        cfg_write(8'd2, 4'b0001);
        set_id(0, 8'd2);
        sync_enable = 4'b0001;
        tick();
        sync_enable = 4'b0000;
        checks++; if (sync_ready !== 4'b0000) begin errors++; $display("FAIL single_n1: got %b expected %b", sync_ready, 4'b0000); end
        tick();
        checks++; if (sync_ready !== 4'b0001) begin errors++; $display("FAIL single_n2: got %b expected %b", sync_ready, 4'b0001); end
        tick();
        checks++; if (sync_ready !== 4'b0000) begin errors++; $display("FAIL single_n3: got %b expected %b", sync_ready, 4'b0000); end
    endtask

    task automatic test_mismatch();
        cfg_write(8'd7, 4'b0110);
        set_id(1, 8'd7);
        set_id(2, 8'd7);
        set_id(3, 8'd9);
        sync_enable = 4'b1110;
        tick();
        sync_enable = 4'b0000;
        checks++; if (err_mismatch !== 1'b1 || err_nonmember !== 1'b0) begin errors++; $display("FAIL mism_flags: got mism=%b nonmem=%b expected mism=1 nonmem=0", err_mismatch, err_nonmember); end
        checks++; if (active_barrier !== 8'd7) begin errors++; $display("FAIL mism_active: got %0d expected %0d", active_barrier, 8'd7); end
        tick();
        checks++; if (sync_ready !== 4'b0110) begin errors++; $display("FAIL mism_release: got %b expected %b", sync_ready, 4'b0110); end
        tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checks++; if (err_mismatch !== 1'b0) begin errors++; $display("FAIL mism_clear: got %b expected %b", err_mismatch, 1'b0); end
    endtask

    task automatic test_timeout();
        logic [3:0] seen;
        seen = 4'b0000;
        cfg_write(8'd1, 4'b0011);
        set_id(0, 8'd1);
        sync_enable = 4'b0001;
        tick();
        sync_enable = 4'b0000;
        for (int i = 0; i < 99; i++) begin
            tick();
            seen = seen | sync_ready;
        end
        checks++; if (busy !== 1'b1 || err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_last: got busy=%b tmo=%b expected busy=1 tmo=0", busy, err_timeout); end
        tick();
        seen = seen | sync_ready;
        checks++; if (err_timeout !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL tmo_fire: got tmo=%b busy=%b expected tmo=1 busy=0", err_timeout, busy); end
        checks++; if (seen !== 4'b0000) begin errors++; $display("FAIL tmo_noready: got %b expected %b", seen, 4'b0000); end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b expected %b", err_timeout, 1'b0); end
    endtask

    task automatic test_reset_in_collect();
        cfg_write(8'd3, 4'b0011);
        set_id(0, 8'd3);
        set_id(1, 8'd4);
        sync_enable = 4'b0011;
        tick();
        sync_enable = 4'b0000;
        checks++; if (busy !== 1'b1 || err_mismatch !== 1'b1) begin errors++; $display("FAIL rst_pre: got busy=%b mism=%b expected busy=1 mism=1", busy, err_mismatch); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if ({sync_ready, busy, active_barrier} !== 13'd0) begin errors++; $display("FAIL rst_outs: got ready=%b busy=%b active=%0d expected all 0", sync_ready, busy, active_barrier); end
        checks++; if ({err_mismatch, err_nonmember, err_timeout, err_overrun} !== 4'b0000) begin errors++; $display("FAIL rst_errs: got %b expected %b", {err_mismatch, err_nonmember, err_timeout, err_overrun}, 4'b0000); end
        tick();
        tick();
        checks++; if (busy !== 1'b0 || sync_ready !== 4'b0000) begin errors++; $display("FAIL rst_quiet: got busy=%b ready=%b expected busy=0 ready=0000", busy, sync_ready); end
        set_id(0, 8'd3);
        sync_enable = 4'b0001;
        tick();
        sync_enable = 4'b0000;
        checks++; if (err_nonmember !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_table: got nonmem=%b busy=%b expected nonmem=1 busy=0", err_nonmember, busy); end
    endtask

    task automatic test_overrun();
        cfg_write(8'd4, 4'b0011);
        set_id(0, 8'd4);
        set_id(1, 8'd4);
        sync_enable = 4'b0011;
        tick();
        sync_enable = 4'b0000;
        tick();
        checks++; if (sync_ready !== 4'b0011) begin errors++; $display("FAIL ovr_release: got %b expected %b", sync_ready, 4'b0011); end
        set_id(2, 8'd4);
        sync_enable = 4'b0100;
        err_clear   = 1'b1;
        tick();
        sync_enable = 4'b0000;
        err_clear   = 1'b0;
        checks++; if (err_overrun !== 1'b1 || err_nonmember !== 1'b0) begin errors++; $display("FAIL ovr_flags: got ovr=%b nonmem=%b expected ovr=1 nonmem=0", err_overrun, err_nonmember); end
        tick();
        checks++; if (busy !== 1'b0 || sync_ready !== 4'b0000) begin errors++; $display("FAIL ovr_idle: got busy=%b ready=%b expected busy=0 ready=0000", busy, sync_ready); end
        cfg_write(8'd4, 4'b0101);
        sync_enable = 4'b0001;
        tick();
        sync_enable = 4'b0000;
        tick();
        tick();
        checks++; if (sync_ready !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL ovr_nocarry: got ready=%b busy=%b expected ready=0000 busy=1", sync_ready, busy); end
        sync_enable = 4'b0100;
        tick();
        sync_enable = 4'b0000;
        tick();
        checks++; if (sync_ready !== 4'b0101) begin errors++; $display("FAIL ovr_next: got %b expected %b", sync_ready, 4'b0101); end
    endtask

    initial begin
        reset            = 1'b0;
        sync_enable      = 4'b0000;
        sync_barrier     = 32'd0;
        cfg_write_enable = 1'b0;
        cfg_write_addr   = 8'd0;
        cfg_write_mask   = 4'b0000;
        err_clear        = 1'b0;
        test_reset();
        test_two_core();
        test_single_core();
        test_mismatch();
        test_timeout();
        test_reset_in_collect();
        test_overrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_barrier_ctrl.md
Name: sync_barrier_ctrl

Overview:
Central responder for the per-core sync interface. It takes barrier requests (barrier id plus enable pulse) from N_CORES distributed processors. It looks up which cores participate in the requested barrier in a host-written mask table. Once every participating core has arrived, it pulses ready back to those cores in the same cycle. It sits beside the processor cores in the sim top level and drives each core's sync ready input.

Parameters:
N_CORES, 4, number of processor cores served
SYNC_BARRIER_WIDTH, 8, barrier id width; mask table depth = 2**SYNC_BARRIER_WIDTH
TIMEOUT_WIDTH, 16, width of the collect-phase timeout counter
TIMEOUT_CYCLES, 1000, collect-phase abort limit; 0 disables the timeout

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset (reset==0 resets on the clk edge)
sync_enable  input  N_CORES  per-core barrier request, 1-cycle pulse
sync_barrier  input  N_CORES*SYNC_BARRIER_WIDTH  per-core barrier id; core i occupies bits [W*(i+1)-1:W*i]
sync_ready  output  N_CORES  per-core release pulse
cfg_write_enable  input  1  mask table write strobe
cfg_write_addr  input  SYNC_BARRIER_WIDTH  barrier id to configure
cfg_write_mask  input  N_CORES  participating cores for that id
err_clear  input  1  clears all sticky error flags
busy  output  1  high in COLLECT and RELEASE
active_barrier  output  SYNC_BARRIER_WIDTH  id being collected; holds its last value when idle
err_mismatch  output  1  sticky: a request carried an id other than the active one
err_nonmember  output  1  sticky: a requesting core is not in the mask, or the mask is 0
err_timeout  output  1  sticky: collect phase aborted by timeout
err_overrun  output  1  sticky: a request arrived during RELEASE

Behaviour:
- Reset (reset==0 at an edge): the following are all cleared to 0: every output, the mask table, the arrived register and the timeout counter. State goes to IDLE. Reset in any state aborts the barrier with no sync_ready pulse.
- Mask table: 2**W entries x N_CORES bits, written on cfg_write_enable. The write is visible to requests sampled from the next edge onward. A write to the active id during COLLECT does not change the latched active mask.
- State IDLE: on the first edge with any sync_enable bit high:
  - Lead core = lowest index requesting; id = lead core's id.
  - Latch active_barrier = id and active_mask = table[id].
  - arrived = requesting cores whose id matches and that are members of the mask.
  - Go to COLLECT.
- Request filtering (applies in IDLE and COLLECT):
  - A requester with a different id sets err_mismatch; its request is dropped.
  - A non-member requester sets err_nonmember; its request is dropped.
  - If the mask is 0: set err_nonmember and stay in IDLE.
- State COLLECT:
  - Each edge ORs in matching member requests. A repeat request from an already-arrived core is harmless.
  - If arrived==active_mask at an edge: register sync_ready<=active_mask and go to RELEASE.
  - Timeout counter increments on each COLLECT cycle. When it reaches TIMEOUT_CYCLES-1 (and TIMEOUT_CYCLES!=0): set err_timeout, clear arrived, go to IDLE with no ready pulse. Timeout takes priority over a simultaneous completion.
- State RELEASE:
  - sync_ready is high for exactly one cycle.
  - arrived and the counter are cleared; next state is IDLE.
  - Any sync_enable in this cycle is dropped and sets err_overrun.
- Latency: the final required sync_enable is high in cycle n, and sync_ready is high in cycle n+2. This also applies to a single-core barrier whose only request is sampled in IDLE.
- Errors: sticky until err_clear or reset. If err_clear and a new error occur in the same cycle, the flag is set (set wins).
- sync_ready is never asserted to a core outside active_mask.

Decomposition:
- Shared package sync_ctrl_pkg:
  - state enum {IDLE, COLLECT, RELEASE}
  - error index constants
  - helper function extracting core i's id from the packed bus
- Sub-module sync_mask_table: register-array mask storage with a write port and a combinational read. It uses the same synchronous active-low reset clear.

Test Plan:
1. Write mask 4'b0011 to id 5. Core0 requests id 5 in cycle 10, core1 in cycle 14. Expect sync_ready=4'b0011 in cycle 16 only, busy from cycle 11 to 16, no errors.
2. Write mask 4'b0001 to id 2. Core0 requests in cycle 20. Expect sync_ready=4'b0001 in cycle 22.
3. Mask 4'b0110 on id 7. Core1 and core2 request id 7 and core3 requests id 9, all in the same cycle. Expect err_mismatch=1 and err_nonmember=0. Core1 and core2 are released 2 cycles later; core3 gets no ready.
4. TIMEOUT_CYCLES=100, mask 4'b0011 on id 1, only core0 requests. Expect err_timeout after 100 COLLECT cycles, no sync_ready, busy=0. err_clear then returns the flag to 0.
5. Reset asserted (0) for one cycle while in COLLECT with arrived=4'b0001. Expect all outputs 0 and the table cleared. A subsequent request to the old id sets err_nonmember.
6. Core2 requests during the RELEASE cycle of a 4'b0011 barrier. Expect err_overrun=1, and core2's request is not carried into the next barrier.
